// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor and the execute-stage resolver.
package branch_pkg;

  // PCsrcE encoding that identifies a conditional branch in E.
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;

  // One pipeline-stage prediction record.
  typedef struct packed {
    logic valid;
    logic taken;
  } pred_rec_t;

  // Empty record used for resets, flushes and bubbles.
  localparam pred_rec_t PRED_REC_NONE = '{valid: 1'b0, taken: 1'b0};

  // Build the record that F hands to D each cycle.
  function automatic pred_rec_t make_fetch_rec(input logic taken);
    pred_rec_t rec;
    rec.valid = 1'b1;
    rec.taken = taken;
    return rec;
  endfunction

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         inc,
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] count
);

  logic at_max;

  // Saturation detect: the counter is full when every bit is set.
  always_comb begin
    at_max = &count;
  end

  // Count register: clears on reset, advances on inc until full.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Carries fetch-time predictions to E, compares them with the resolved
// outcome, and raises a self-flushing mispredict with the corrected PC.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_takenF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic [1:0]       PCsrcE,
  input  logic             BranchCondE,
  input  logic [PC_W-1:0]  PCTargetE,
  input  logic [PC_W-1:0]  PCPlus4E,
  output logic             pred_takenE,
  output logic             MispredictE,
  output logic [PC_W-1:0]  RedirectPCE,
  output logic             UpdateEnE,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  pred_rec_t reg_d;
  pred_rec_t reg_e;

  logic clear_d;
  logic clear_e;

  // A mispredict squashes both younger records, independent of the hazard unit.
  always_comb begin
    clear_d = reset | MispredictE | FlushD;
    clear_e = reset | MispredictE | FlushE;
  end

  // D record: flush beats stall, stall beats a fresh capture from F.
  always_ff @(posedge clk) begin
    if (clear_d) begin
      reg_d <= PRED_REC_NONE;
    end else if (!StallD) begin
      reg_d <= make_fetch_rec(pred_takenF);
    end
  end

  // E record: always follows D unless flushed; stalls are bubbled via FlushE.
  always_ff @(posedge clk) begin
    if (clear_e) begin
      reg_e <= PRED_REC_NONE;
    end else begin
      reg_e <= reg_d;
    end
  end

  // Resolution in E: only valid conditional branches are compared.
  always_comb begin
    pred_takenE = reg_e.taken;
    UpdateEnE   = reg_e.valid & (PCsrcE == PCSRC_BRANCH);
    MispredictE = UpdateEnE & (BranchCondE != reg_e.taken);
    RedirectPCE = BranchCondE ? PCTargetE : PCPlus4E;
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .inc   (UpdateEnE),
    .clk   (clk),
    .reset (reset),
    .count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .inc   (MispredictE),
    .clk   (clk),
    .reset (reset),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with 4-bit performance counters.
module tb_branch_resolver;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             pred_takenF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       PCsrcE;
  logic             BranchCondE;
  logic [PC_W-1:0]  PCTargetE;
  logic [PC_W-1:0]  PCPlus4E;
  logic             pred_takenE;
  logic             MispredictE;
  logic [PC_W-1:0]  RedirectPCE;
  logic             UpdateEnE;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  int compared;
  int mismatched;
  int seen;

  branch_resolver #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_takenF      (pred_takenF),
    .StallD           (StallD),
    .FlushD           (FlushD),
    .FlushE           (FlushE),
    .PCsrcE           (PCsrcE),
    .BranchCondE      (BranchCondE),
    .PCTargetE        (PCTargetE),
    .PCPlus4E         (PCPlus4E),
    .pred_takenE      (pred_takenE),
    .MispredictE      (MispredictE),
    .RedirectPCE      (RedirectPCE),
    .UpdateEnE        (UpdateEnE),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle, so inputs change and outputs are read away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set the E-stage branch inputs, then let the combinational outputs settle.
  task automatic apply_stimulus(input logic [1:0] pcsrc, input logic cond,
                                input logic [31:0] target, input logic [31:0] plus4);
    PCsrcE      = pcsrc;
    BranchCondE = cond;
    PCTargetE   = target;
    PCPlus4E    = plus4;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    seen        = 0;
    reset       = 1'b1;
    pred_takenF = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    PCsrcE      = 2'b00;
    BranchCondE = 1'b0;
    PCTargetE   = '0;
    PCPlus4E    = '0;

    tick();
    tick();
    reset = 1'b0;
    apply_stimulus(2'b01, 1'b1, 32'h0, 32'h0);
    check_output("reset_predE", {31'b0, pred_takenE}, 32'd0);
    check_output("reset_mispred", {31'b0, MispredictE}, 32'd0);
    check_output("reset_upd", {31'b0, UpdateEnE}, 32'd0);
    check_output("reset_bcnt", {28'b0, branch_count}, 32'd0);
    check_output("reset_mcnt", {28'b0, mispredict_count}, 32'd0);

    // Correctly predicted taken branch.
    $display("[TB] correct taken prediction");
    apply_stimulus(2'b00, 1'b0, 32'h0, 32'h0);
    pred_takenF = 1'b1;
    tick();
    tick();
    apply_stimulus(2'b01, 1'b1, 32'h80, 32'h10);
    check_output("t1_predE", {31'b0, pred_takenE}, 32'd1);
    check_output("t1_mispred", {31'b0, MispredictE}, 32'd0);
    check_output("t1_upd", {31'b0, UpdateEnE}, 32'd1);
    tick();
    apply_stimulus(2'b00, 1'b0, 32'h0, 32'h0);
    check_output("t1_bcnt", {28'b0, branch_count}, 32'd1);
    check_output("t1_mcnt", {28'b0, mispredict_count}, 32'd0);

    // Predicted not-taken, actually taken.
    $display("[TB] not-taken prediction resolves taken");
    pred_takenF = 1'b0;
    tick();
    tick();
    apply_stimulus(2'b01, 1'b1, 32'h100, 32'h24);
    check_output("t2_predE", {31'b0, pred_takenE}, 32'd0);
    check_output("t2_mispred", {31'b0, MispredictE}, 32'd1);
    check_output("t2_redirect", RedirectPCE, 32'h100);
    pred_takenF = 1'b1;
    tick();
    apply_stimulus(2'b01, 1'b0, 32'h100, 32'h24);
    check_output("t2_e_cleared", {31'b0, UpdateEnE}, 32'd0);
    check_output("t2_mcnt", {28'b0, mispredict_count}, 32'd1);
    check_output("t2_bcnt", {28'b0, branch_count}, 32'd2);
    tick();
    check_output("t2_d_cleared", {31'b0, UpdateEnE}, 32'd0);

    // Predicted taken, actually not taken.
    $display("[TB] taken prediction resolves not-taken");
    tick();
    apply_stimulus(2'b01, 1'b0, 32'h300, 32'h48);
    check_output("t3_predE", {31'b0, pred_takenE}, 32'd1);
    check_output("t3_mispred", {31'b0, MispredictE}, 32'd1);
    check_output("t3_redirect", RedirectPCE, 32'h48);
    tick();
    apply_stimulus(2'b00, 1'b0, 32'h0, 32'h0);
    check_output("t3_mcnt", {28'b0, mispredict_count}, 32'd2);
    check_output("t3_bcnt", {28'b0, branch_count}, 32'd3);

    // Stall D for two cycles while E receives bubbles.
    $display("[TB] stall with bubbles");
    pred_takenF = 1'b1;
    tick();
    pred_takenF = 1'b0;
    StallD      = 1'b1;
    FlushE      = 1'b1;
    tick();
    apply_stimulus(2'b01, 1'b1, 32'h0, 32'h0);
    check_output("t4_bubble1_upd", {31'b0, UpdateEnE}, 32'd0);
    tick();
    check_output("t4_bubble2_upd", {31'b0, UpdateEnE}, 32'd0);
    check_output("t4_bubble2_predE", {31'b0, pred_takenE}, 32'd0);
    StallD = 1'b0;
    FlushE = 1'b0;
    tick();
    check_output("t4_arrive_predE", {31'b0, pred_takenE}, 32'd1);
    check_output("t4_arrive_upd", {31'b0, UpdateEnE}, 32'd1);
    check_output("t4_arrive_mispred", {31'b0, MispredictE}, 32'd0);
    tick();
    apply_stimulus(2'b10, 1'b1, 32'h200, 32'h60);
    check_output("t4_bcnt", {28'b0, branch_count}, 32'd4);

    // Jump in E: never compared, never counted.
    $display("[TB] jump in E");
    check_output("t5_predE", {31'b0, pred_takenE}, 32'd0);
    check_output("t5_mispred", {31'b0, MispredictE}, 32'd0);
    check_output("t5_upd", {31'b0, UpdateEnE}, 32'd0);
    check_output("t5_redirect", RedirectPCE, 32'h200);
    tick();
    check_output("t5_bcnt", {28'b0, branch_count}, 32'd4);
    check_output("t5_mcnt", {28'b0, mispredict_count}, 32'd2);

    // A stream of mispredicting branches drives both counters into saturation.
    $display("[TB] counter saturation");
    pred_takenF = 1'b0;
    apply_stimulus(2'b01, 1'b1, 32'h400, 32'h70);
    for (int i = 0; i < 200 && seen < 20; i++) begin
      tick();
      if (MispredictE === 1'b1) seen++;
    end
    check_output("t6_mispredicts_seen", seen, 32'd20);
    tick();
    check_output("t6_bcnt_sat", {28'b0, branch_count}, 32'd15);
    check_output("t6_mcnt_sat", {28'b0, mispredict_count}, 32'd15);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_output("t6_reset_bcnt", {28'b0, branch_count}, 32'd0);
    check_output("t6_reset_mcnt", {28'b0, mispredict_count}, 32'd0);
    check_output("t6_reset_upd", {31'b0, UpdateEnE}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
